// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exccode_e;

    localparam logic [31:0] PRID       = 32'h2021_0707;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam int unsigned SR_IE        = 0;
    localparam int unsigned SR_EXL       = 1;
    localparam int unsigned SR_IM_LO     = 10;
    localparam int unsigned SR_IM_HI     = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_BD     = 31;

    // Return address for a victim: word-aligned, backed up one slot in a delay slot.
    function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
        logic [31:0] aligned;
        aligned = pc & 32'hffff_fffc;
        return bd ? aligned - 32'd4 : aligned;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller at the M stage: request decision, SR/Cause/EPC
// register file, mfc0/mtc0/eret semantics and the EPC bypass to fetch.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID       = cp0_exc_ctrl_pkg::PRID,
    parameter logic [31:0] HANDLER_PC = cp0_exc_ctrl_pkg::HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exccode_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] EPC,
    output logic [31:0] handler_pc
);
    import cp0_exc_ctrl_pkg::*;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [4:0]  code_taken;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    always_comb begin
        int_req    = ie_q & ~exl_q & (|(hw_int & im_q));
        exc_req    = ~exl_q & (exccode_in != '0);
        req        = int_req | exc_req;
        code_taken = int_req ? EXC_INT : exccode_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q   <= '0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= '0;
            code_q <= '0;
            epc_q  <= '0;
        end else begin
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            ip_q   <= ip_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

    // A taken request overrides any mtc0 or eret in the same cycle.
    always_comb begin
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        ip_d   = hw_int;
        code_d = code_q;
        epc_d  = epc_q;
        if (req) begin
            exl_d  = 1'b1;
            code_d = code_taken;
            bd_d   = bd_in;
            epc_d  = victim_epc(vpc, bd_in);
        end else begin
            if (we && addr == CP0_SR) begin
                im_d  = wdata[SR_IM_HI:SR_IM_LO];
                exl_d = wdata[SR_EXL];
                ie_d  = wdata[SR_IE];
            end
            if (we && addr == CP0_EPC) begin
                epc_d = wdata;
            end
            if (eret) begin
                exl_d = 1'b0;
            end
        end
    end

    always_comb begin
        sr_val                           = '0;
        sr_val[SR_IM_HI:SR_IM_LO]        = im_q;
        sr_val[SR_EXL]                   = exl_q;
        sr_val[SR_IE]                    = ie_q;
        cause_val                        = '0;
        cause_val[CAUSE_BD]              = bd_q;
        cause_val[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
        cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO] = code_q;

        case (addr)
            CP0_SR:    rdata = sr_val;
            CP0_CAUSE: rdata = cause_val;
            CP0_EPC:   rdata = epc_q;
            CP0_PRID:  rdata = PRID;
            default:   rdata = '0;
        endcase

        EPC        = (we && addr == CP0_EPC) ? wdata : epc_q;
        handler_pc = HANDLER_PC;
    end

endmodule
